// File: rtl/instr_stream_encoder_pkg.sv
// Shared opcode, kind and state constants for the instruction stream encoder
// and the control decoder that reads the same encodings back.
package instr_stream_encoder_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    typedef enum logic [3:0] {
        KIND_R    = 4'd0,
        KIND_ADDI = 4'd1,
        KIND_SLTI = 4'd2,
        KIND_BEQ  = 4'd3,
        KIND_LW   = 4'd4,
        KIND_SW   = 4'd5,
        KIND_J    = 4'd6,
        KIND_JAL  = 4'd7,
        KIND_JR   = 4'd8
    } kind_e;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCEPT = 2'd1;
    localparam logic [1:0] ST_WRITE  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    function automatic logic [31:0] enc_itype(input logic [5:0] op, input logic [4:0] rs,
                                              input logic [4:0] rt, input logic [15:0] imm16);
        return {op, rs, rt, imm16};
    endfunction

endpackage

// File: rtl/instr_stream_encoder_if.sv
// Descriptor input and instruction-memory write port of the stream encoder.
interface instr_stream_encoder_if #(parameter int ADDR_W = 8);

    logic              start_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [3:0]        kind_i;
    logic [4:0]        rs_i;
    logic [4:0]        rt_i;
    logic [4:0]        rd_i;
    logic [4:0]        shamt_i;
    logic [5:0]        funct_i;
    logic [25:0]       imm_i;
    logic              last_i;
    logic              mem_req_o;
    logic              mem_ack_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic              busy_o;
    logic              done_o;
    logic              full_o;
    logic              err_o;
    logic [ADDR_W:0]   count_o;

    // Handshakes: a descriptor transfers on a rising edge where in_valid_i && in_ready_o;
    // a write completes on a rising edge where mem_req_o && mem_ack_i, and until then
    // mem_addr_o/mem_wdata_o hold still.
    modport master (
        input  start_i, base_addr_i, in_valid_i, kind_i, rs_i, rt_i, rd_i, shamt_i,
               funct_i, imm_i, last_i, mem_ack_i,
        output in_ready_o, mem_req_o, mem_addr_o, mem_wdata_o, busy_o, done_o, full_o,
               err_o, count_o
    );

    modport slave (
        output start_i, base_addr_i, in_valid_i, kind_i, rs_i, rt_i, rd_i, shamt_i,
               funct_i, imm_i, last_i, mem_ack_i,
        input  in_ready_o, mem_req_o, mem_addr_o, mem_wdata_o, busy_o, done_o, full_o,
               err_o, count_o
    );

endinterface

// File: rtl/instr_stream_encoder_word.sv
// Combinational packer: descriptor fields -> 32-bit MIPS word plus illegal-kind flag.
module instr_word_encoder
    import instr_stream_encoder_pkg::*;
(
    input  logic [3:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [25:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (kind)
            KIND_R:    word = {OP_RTYPE, rs, rt, rd, shamt, funct};
            KIND_ADDI: word = enc_itype(OP_ADDI, rs, rt, imm[15:0]);
            KIND_SLTI: word = enc_itype(OP_SLTI, rs, rt, imm[15:0]);
            KIND_BEQ:  word = enc_itype(OP_BEQ,  rs, rt, imm[15:0]);
            KIND_LW:   word = enc_itype(OP_LW,   rs, rt, imm[15:0]);
            KIND_SW:   word = enc_itype(OP_SW,   rs, rt, imm[15:0]);
            KIND_J:    word = {OP_J,   imm};
            KIND_JAL:  word = {OP_JAL, imm};
            // jr ignores rt/rd/shamt so stale descriptor fields never leak into the word
            KIND_JR:   word = {OP_RTYPE, rs, 15'd0, FUNCT_JR};
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_stream_encoder.sv
// Accepts instruction descriptors, encodes them and writes them to consecutive
// instruction-memory words, one request/ack transaction per word.
module instr_stream_encoder
    import instr_stream_encoder_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    instr_stream_encoder_if.master bus,
    output logic [1:0]             dbg_state
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [1:0]        state;
    logic              last_q;
    logic              err_q;
    logic              full_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q;
    logic [31:0]       wdata_q;
    logic [31:0]       enc_word;
    logic              enc_illegal;
    logic [ADDR_W:0]   count_nxt;

    instr_word_encoder u_enc (
        .kind    (bus.kind_i),
        .rs      (bus.rs_i),
        .rt      (bus.rt_i),
        .rd      (bus.rd_i),
        .shamt   (bus.shamt_i),
        .funct   (bus.funct_i),
        .imm     (bus.imm_i),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign count_nxt = count_q + 1'b1;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state   <= ST_IDLE;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            full_q  <= 1'b0;
            addr_q  <= '0;
            count_q <= '0;
            wdata_q <= '0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        state   <= ST_ACCEPT;
                        addr_q  <= bus.base_addr_i;
                        count_q <= '0;
                        full_q  <= 1'b0;
                    end
                end
                ST_ACCEPT: begin
                    if (bus.in_valid_i) begin
                        if (enc_illegal) begin
                            err_q <= 1'b1;
                            state <= bus.last_i ? ST_DONE : ST_ACCEPT;
                        end else begin
                            wdata_q <= enc_word;
                            last_q  <= bus.last_i;
                            state   <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (bus.mem_ack_i) begin
                        addr_q  <= addr_q + 1'b1;
                        count_q <= count_nxt;
                        // Running out of space ends the program even without a last descriptor
                        if (last_q || count_nxt == DEPTH_C) begin
                            state  <= ST_DONE;
                            full_q <= (count_nxt == DEPTH_C);
                        end else begin
                            state <= ST_ACCEPT;
                        end
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready_o  = (state == ST_ACCEPT);
    assign bus.mem_req_o   = (state == ST_WRITE);
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.busy_o      = (state != ST_IDLE);
    assign bus.done_o      = (state == ST_DONE);
    assign bus.full_o      = full_q;
    assign bus.err_o       = err_q;
    assign bus.count_o     = count_q;
    assign dbg_state       = state;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Directed bench for instr_stream_encoder: encoding table, multi-word programs,
// delayed ack, illegal kinds, DEPTH wrap/full, reset mid-write and start while busy.
module tb_instr_stream_encoder;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic [1:0] dbg_state;

    instr_stream_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instr_stream_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .bus       (bus.master),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  kind;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  funct;
        logic [25:0] imm;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs[10];

    int n_vec = 0;
    int n_err = 0;
    int ack_delay = 0;
    int req_cycles = 0;
    logic [ADDR_W-1:0] held_addr;
    logic [31:0]       held_data;
    logic [ADDR_W+31:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory responder and write scoreboard, evaluated on the falling edge.
    always @(negedge clk) begin
        logic [ADDR_W+31:0] e;
        if (bus.mem_req_o) begin
            if (req_cycles == 0) begin
                held_addr = bus.mem_addr_o;
                held_data = bus.mem_wdata_o;
            end else begin
                check("hold_addr", 64'(bus.mem_addr_o), 64'(held_addr));
                check("hold_data", 64'(bus.mem_wdata_o), 64'(held_data));
                check("ready_in_write", 64'(bus.in_ready_o), 64'd0);
            end
            if (req_cycles >= ack_delay) begin
                bus.mem_ack_i = 1'b1;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                             bus.mem_addr_o, bus.mem_wdata_o);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(bus.mem_addr_o), 64'(e[ADDR_W+31:32]));
                    check("wr_data", 64'(bus.mem_wdata_o), 64'(e[31:0]));
                end
            end else begin
                bus.mem_ack_i = 1'b0;
            end
            req_cycles++;
        end else begin
            bus.mem_ack_i = 1'b0;
            req_cycles = 0;
        end
    end

    task automatic start_prog(input logic [ADDR_W-1:0] base);
        bus.start_i     = 1'b1;
        bus.base_addr_i = base;
        @(negedge clk);
        bus.start_i     = 1'b0;
    endtask

    task automatic send(input logic [3:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] shamt, input logic [5:0] funct,
                        input logic [25:0] imm, input logic last);
        int t = 0;
        bus.kind_i = kind; bus.rs_i = rs; bus.rt_i = rt; bus.rd_i = rd;
        bus.shamt_i = shamt; bus.funct_i = funct; bus.imm_i = imm; bus.last_i = last;
        bus.in_valid_i = 1'b1;
        while (!bus.in_ready_o && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready_o) begin
            check("ready_timeout", 64'(bus.in_ready_o), 64'd1);
            bus.in_valid_i = 1'b0;
        end else begin
            @(negedge clk);
            bus.in_valid_i = 1'b0;
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while (!bus.done_o && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", 64'(bus.done_o), 64'd1);
    endtask

    task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [31:0] w);
        exp_q.push_back({a, w});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{KIND_ADDI_C(), 5'd1,  5'd2,  5'd0,  5'd0, 6'h00, 26'h0000005, 32'h20220005};
        vecs[1] = '{4'd0,          5'd1,  5'd2,  5'd3,  5'd0, 6'h20, 26'h0000000, 32'h00221820};
        vecs[2] = '{4'd4,          5'd29, 5'd8,  5'd0,  5'd0, 6'h00, 26'h0000004, 32'h8FA80004};
        vecs[3] = '{4'd8,          5'd31, 5'd5,  5'd7,  5'd3, 6'h3F, 26'h3FFFFFF, 32'h03E00008};
        vecs[4] = '{4'd7,          5'd0,  5'd0,  5'd0,  5'd0, 6'h00, 26'h0000010, 32'h0C000010};
        vecs[5] = '{4'd6,          5'd0,  5'd0,  5'd0,  5'd0, 6'h00, 26'h3FFFFFF, 32'h0BFFFFFF};
        vecs[6] = '{4'd2,          5'd3,  5'd4,  5'd0,  5'd0, 6'h00, 26'h3FFFFFF, 32'h2864FFFF};
        vecs[7] = '{4'd3,          5'd5,  5'd6,  5'd0,  5'd0, 6'h00, 26'h0000010, 32'h10A60010};
        vecs[8] = '{4'd5,          5'd29, 5'd31, 5'd0,  5'd0, 6'h00, 26'h0008000, 32'hAFBF8000};
        vecs[9] = '{4'd0,          5'd0,  5'd9,  5'd10, 5'd4, 6'h00, 26'h0000000, 32'h00095100};

        bus.start_i = 1'b0; bus.base_addr_i = '0; bus.in_valid_i = 1'b0;
        bus.kind_i = '0; bus.rs_i = '0; bus.rt_i = '0; bus.rd_i = '0; bus.shamt_i = '0;
        bus.funct_i = '0; bus.imm_i = '0; bus.last_i = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req",   64'(bus.mem_req_o),   64'd0);
        check("rst_addr",  64'(bus.mem_addr_o),  64'd0);
        check("rst_wdata", 64'(bus.mem_wdata_o), 64'd0);
        check("rst_busy",  64'(bus.busy_o),      64'd0);
        check("rst_done",  64'(bus.done_o),      64'd0);
        check("rst_full",  64'(bus.full_o),      64'd0);
        check("rst_err",   64'(bus.err_o),       64'd0);
        check("rst_count", 64'(bus.count_o),     64'd0);
        check("rst_ready", 64'(bus.in_ready_o),  64'd0);
        check("rst_state", 64'(dbg_state),       64'd0);
        rst_i = 1'b1;
        @(negedge clk);

        // Encoding table: one single-word program per vector
        for (int i = 0; i < 10; i++) begin
            logic [ADDR_W-1:0] base;
            base = ADDR_W'(8'h20 + i);
            start_prog(base);
            push_exp(base, vecs[i].exp_word);
            send(vecs[i].kind, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].shamt,
                 vecs[i].funct, vecs[i].imm, 1'b1);
            wait_done();
            check("tbl_count", 64'(bus.count_o), 64'd1);
            check("tbl_next_addr", 64'(bus.mem_addr_o), 64'(base + 8'd1));
            @(negedge clk);
            check("tbl_idle", 64'(bus.busy_o), 64'd0);
        end

        // Two-word program: add then lw
        start_prog(8'h10);
        push_exp(8'h10, 32'h00221820);
        push_exp(8'h11, 32'h8FA80004);
        send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 26'd0, 1'b0);
        send(4'd4, 5'd29, 5'd8, 5'd0, 5'd0, 6'h00, 26'd4, 1'b1);
        wait_done();
        check("two_count", 64'(bus.count_o), 64'd2);
        check("two_full", 64'(bus.full_o), 64'd0);
        @(negedge clk);

        // Ack delayed 3 cycles; responder checks hold and in_ready_o meanwhile
        ack_delay = 3;
        start_prog(8'h70);
        push_exp(8'h70, 32'h20220005);
        send(4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 26'd5, 1'b1);
        check("dly_req", 64'(bus.mem_req_o), 64'd1);
        wait_done();
        check("dly_count", 64'(bus.count_o), 64'd1);
        ack_delay = 0;
        @(negedge clk);

        // Illegal kind, not last: dropped, err pulse, back in ACCEPT
        start_prog(8'h30);
        send(4'd12, 5'd1, 5'd2, 5'd3, 5'd0, 6'h00, 26'd0, 1'b0);
        check("ill_err", 64'(bus.err_o), 64'd1);
        check("ill_noreq", 64'(bus.mem_req_o), 64'd0);
        check("ill_ready", 64'(bus.in_ready_o), 64'd1);
        @(negedge clk);
        check("ill_err_pulse", 64'(bus.err_o), 64'd0);
        push_exp(8'h30, 32'h20220005);
        send(4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 26'd5, 1'b1);
        wait_done();
        check("ill_count", 64'(bus.count_o), 64'd1);
        @(negedge clk);

        // Illegal kind marked last ends the program with nothing written
        start_prog(8'h50);
        send(4'd9, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 26'd0, 1'b1);
        check("ill_last_err", 64'(bus.err_o), 64'd1);
        check("ill_last_done", 64'(bus.done_o), 64'd1);
        check("ill_last_count", 64'(bus.count_o), 64'd0);
        @(negedge clk);
        check("ill_last_idle", 64'(bus.busy_o), 64'd0);

        // DEPTH limit with address wrap: base 0xFE, descriptors never marked last
        start_prog(8'hFE);
        push_exp(8'hFE, 32'h00000001);
        push_exp(8'hFF, 32'h00000002);
        push_exp(8'h00, 32'h00000003);
        push_exp(8'h01, 32'h00000004);
        for (int k = 1; k <= 4; k++)
            send(4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'(k), 26'd0, 1'b0);
        wait_done();
        check("full_flag", 64'(bus.full_o), 64'd1);
        check("full_count", 64'(bus.count_o), 64'd4);
        check("full_addr", 64'(bus.mem_addr_o), 64'h02);
        // Descriptors 5 and 6 are offered but must not be taken
        bus.kind_i = 4'd0; bus.funct_i = 6'd5; bus.last_i = 1'b0;
        bus.in_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("full_no_ready", 64'(bus.in_ready_o), 64'd0);
            check("full_held", 64'(bus.full_o), 64'd1);
        end
        bus.in_valid_i = 1'b0;
        start_prog(8'h00);
        check("full_cleared", 64'(bus.full_o), 64'd0);
        push_exp(8'h00, 32'h0C000010);
        send(4'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 26'h10, 1'b1);
        wait_done();
        @(negedge clk);

        // Reset during WRITE: request dropped immediately, no ack awaited
        ack_delay = 100;
        start_prog(8'h60);
        send(4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 26'd5, 1'b1);
        check("rw_req_before", 64'(bus.mem_req_o), 64'd1);
        rst_i = 1'b0;
        @(negedge clk);
        check("rw_req_after", 64'(bus.mem_req_o), 64'd0);
        check("rw_busy_after", 64'(bus.busy_o), 64'd0);
        check("rw_count_after", 64'(bus.count_o), 64'd0);
        rst_i = 1'b1;
        ack_delay = 0;
        @(negedge clk);

        // start_i while busy is ignored: base stays 0x40
        start_prog(8'h40);
        bus.start_i = 1'b1;
        bus.base_addr_i = 8'h80;
        @(negedge clk);
        bus.start_i = 1'b0;
        check("sb_busy", 64'(bus.busy_o), 64'd1);
        check("sb_ready", 64'(bus.in_ready_o), 64'd1);
        check("sb_addr", 64'(bus.mem_addr_o), 64'h40);
        push_exp(8'h40, 32'h03E00008);
        send(4'd8, 5'd31, 5'd0, 5'd0, 5'd0, 6'h00, 26'd0, 1'b1);
        wait_done();
        check("sb_next_addr", 64'(bus.mem_addr_o), 64'h41);
        @(negedge clk);
        repeat (2) @(negedge clk);

        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    function automatic logic [3:0] KIND_ADDI_C();
        return 4'd1;
    endfunction

endmodule
